// File: rtl/fir_pkg.sv
// Shared constants for the 6-tap symmetric FIR [1 2 3 3 2 1] and its exact inverse.
// Coefficients, tap counts and decoder state encodings are common to encoder and decoder.
package fir_pkg;

    localparam int TAPS = 6;
    localparam int HIST = TAPS - 1;

    // COEF[0] is the leading coefficient; it must stay 1 for the inverse to be exact.
    localparam int COEF [TAPS] = '{1, 2, 3, 3, 2, 1};

    // Largest coefficient the shift/add term builder supports (two partial products).
    localparam int COEF_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } fir_state_t;

    function automatic bit coef_uses_shift(input int idx);
        return (COEF[idx] & 2) != 0;
    endfunction

    function automatic bit coef_uses_plain(input int idx);
        return (COEF[idx] & 1) != 0;
    endfunction

endpackage

// File: rtl/fir_inv_hist.sv
// Five-entry history of recovered samples; h[0] is the newest.
// Shifts on every accepted sample; clear and reset both zero the whole line.
module fir_inv_hist
    import fir_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        shift,
    input  logic [WIDTH-1:0]            din,
    output logic [HIST-1:0][WIDTH-1:0]  taps
);

    logic [WIDTH-1:0] h_reg [HIST];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HIST; i++) begin
                h_reg[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < HIST; i++) begin
                h_reg[i] <= '0;
            end
        end else if (shift) begin
            for (int i = HIST - 1; i > 0; i--) begin
                h_reg[i] <= h_reg[i-1];
            end
            h_reg[0] <= din;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < HIST; gi++) begin : g_tap
            assign taps[gi] = h_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/fir_inv.sv
// Exact inverse of the [1 2 3 3 2 1] FIR: x_hat = y - sum(coef[k] * h[k]), modulo 2^WIDTH.
// One-deep output register with valid/ready handshake; accepts a new sample whenever it drains.
module fir_inv
    import fir_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sample_cnt
);

    logic [HIST-1:0][WIDTH-1:0] taps;
    logic [WIDTH-1:0]           term [HIST];
    logic [WIDTH-1:0]           tap_sum;
    logic [WIDTH-1:0]           x_hat;
    logic                       in_xfer;
    logic                       out_xfer;

    fir_state_t       state_reg, state_next;
    logic             valid_reg, valid_next;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Each coefficient (<= 3) is built from at most a shifted copy plus a plain copy.
    genvar gi;
    generate
        for (gi = 0; gi < HIST; gi++) begin : g_term
            localparam bit USE_SHIFT = coef_uses_shift(gi + 1);
            localparam bit USE_PLAIN = coef_uses_plain(gi + 1);
            logic [WIDTH-1:0] part_shift;
            logic [WIDTH-1:0] part_plain;
            if (USE_SHIFT) begin : g_shift
                assign part_shift = taps[gi] << 1;
            end else begin : g_no_shift
                assign part_shift = '0;
            end
            if (USE_PLAIN) begin : g_plain
                assign part_plain = taps[gi];
            end else begin : g_no_plain
                assign part_plain = '0;
            end
            assign term[gi] = part_shift + part_plain;
        end
    endgenerate

    always_comb begin
        tap_sum = '0;
        for (int i = 0; i < HIST; i++) begin
            tap_sum = tap_sum + term[i];
        end
        x_hat = in_data - tap_sum;
    end

    assign in_ready = (!valid_reg || out_ready) && !clear;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_reg && out_ready;

    fir_inv_hist #(
        .WIDTH (WIDTH)
    ) u_hist (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .shift (in_xfer),
        .din   (x_hat),
        .taps  (taps)
    );

    // IDLE is only re-entered by reset/clear; a drained output after a stream stays in RUN.
    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        if (clear) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
        end else if (in_xfer) begin
            state_next = ST_RUN;
            valid_next = 1'b1;
        end else begin
            if (out_xfer) begin
                valid_next = 1'b0;
            end
            if (state_reg != ST_IDLE) begin
                state_next = (valid_reg && !out_ready) ? ST_STALL : ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
            cnt_reg  <= '0;
        end else if (clear) begin
            data_reg <= '0;
            cnt_reg  <= '0;
        end else if (in_xfer) begin
            data_reg <= x_hat;
            if (cnt_reg != {CNT_W{1'b1}}) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_data   = data_reg;
    assign out_valid  = valid_reg;
    assign sample_cnt = cnt_reg;

endmodule

// File: tb/tb_fir_inv.sv
// Scoreboard bench for fir_inv: stimulus pushes expected samples, a monitor pops on each output transfer.
module tb_fir_inv;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sample_cnt;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] sb [$];
    logic [31:0] enc_h [5];

    fir_inv #(.WIDTH(32), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder: y = x + 2x1 + 3x2 + 3x3 + 2x4 + x5 mod 2^32.
    task automatic encode(input logic [31:0] x, output logic [31:0] y);
        y = x + 32'd2 * enc_h[0] + 32'd3 * enc_h[1] + 32'd3 * enc_h[2]
              + 32'd2 * enc_h[3] + enc_h[4];
        for (int i = 4; i > 0; i--) enc_h[i] = enc_h[i-1];
        enc_h[0] = x;
    endtask

    task automatic enc_clear();
        for (int i = 0; i < 5; i++) enc_h[i] = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_raw(input logic [31:0] y, input logic [31:0] exp);
        int  n    = 0;
        bit  done = 0;
        in_data  = y;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                sb.push_back(exp);
                $display("in  y=%08h expect x=%08h", y, exp);
                done = 1;
            end else begin
                @(posedge clk);
                n++;
                if (n > 50) begin
                    check("accept_timeout", 64'd0, 64'd1);
                    done = 1;
                end
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_x(input logic [31:0] x);
        logic [31:0] y;
        encode(x, y);
        send_raw(y, x);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        enc_clear();
    endtask

    // Monitor: each output transfer must match the oldest pending expectation.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", {32'd0, out_data}, 64'hFFFF_FFFF_0000_0000);
                end else begin
                    exp = sb.pop_front();
                    $display("out x=%08h expected %08h", out_data, exp);
                    check("out_data", {32'd0, out_data}, {32'd0, exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] IMP_Y  [8] = '{1, 2, 3, 3, 2, 1, 0, 0};
    localparam logic [31:0] IMP_X  [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    localparam logic [31:0] STEP_Y [8] = '{1, 3, 6, 9, 11, 12, 12, 12};
    localparam logic [31:0] WRAP_X [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};

    initial begin
        logic [31:0] y_pend;
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        enc_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_cnt", {48'd0, sample_cnt}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Impulse, back-to-back with full throughput.
        for (int i = 0; i < 8; i++) send_raw(IMP_Y[i], IMP_X[i]);
        drain();
        check("impulse_cnt", {48'd0, sample_cnt}, 64'd8);

        // Step response.
        do_clear();
        for (int i = 0; i < 8; i++) send_raw(STEP_Y[i], 32'd1);
        drain();
        check("step_cnt", {48'd0, sample_cnt}, 64'd8);

        // Wrap-around through the reference encoder.
        do_clear();
        for (int i = 0; i < 4; i++) send_x(WRAP_X[i]);

        // Backpressure: output held three cycles with a sample waiting.
        send_x(32'd10);
        send_x(32'd20);
        out_ready = 1'b0;
        encode(32'd30, y_pend);
        in_data  = y_pend;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold", {32'd0, out_data}, 64'd20);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_raw(y_pend, 32'd30);
        send_x(32'd40);
        drain();

        // Clear with a stalled pending output: the sample is discarded.
        out_ready = 1'b0;
        send_x(32'd50);
        clear = 1'b1;
        @(negedge clk);
        check("clr_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_out_valid", {63'd0, out_valid}, 64'd0);
        check("clr_cnt", {48'd0, sample_cnt}, 64'd0);
        sb.delete();
        enc_clear();
        out_ready = 1'b1;
        send_x(32'd7);
        drain();

        // Asynchronous reset between edges while a sample is pending.
        send_x(32'd1);
        send_x(32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("areset_out_valid", {63'd0, out_valid}, 64'd0);
        check("areset_out_data", {32'd0, out_data}, 64'd0);
        check("areset_cnt", {48'd0, sample_cnt}, 64'd0);
        sb.delete();
        enc_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("areset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_raw(IMP_Y[i], IMP_X[i]);
        drain();
        check("impulse2_cnt", {48'd0, sample_cnt}, 64'd8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
